// File: rtl/online_otf_convert.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : online_otf_convert                                              |
// | Brief    : MSD-first on-the-fly conversion of one redundant signed-digit   |
// |            word into two's complement using Q/QM registers. One digit per  |
// |            clock, parallel load, registered result, valid/ready handshake  |
// |            on input and output.                                            |
// | Options  : OTFC_SAT_EN - when OUT_W < Stage+1 the result saturates         |
// |            instead of wrapping. It has no effect when OUT_W = Stage+1.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module online_otf_convert #(
  parameter int Stage = 9,
  parameter int OUT_W = Stage + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*Stage-1:0] x,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [OUT_W-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int          CW      = $clog2(Stage) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(Stage - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [2*Stage-1:0] sr;
  logic [Stage:0]     q;
  logic [Stage:0]     qm;
  logic [CW-1:0]      cnt;

  logic [1:0]         w_msd;
  logic [Stage:0]     w_q_next;
  logic [Stage:0]     w_qm_next;
  logic [OUT_W-1:0]   w_fit;

  // The digit being consumed this cycle is always the top pair of the shift register.
  assign w_msd = sr[2*Stage-1 -: 2];

  // On-the-fly update: Q holds the prefix value, QM holds prefix minus one ulp,
  // so a -1 digit never needs a borrow chain. Encoding 11 falls into the zero case.
  always_comb begin
    w_q_next  = {q[Stage-1:0], 1'b0};
    w_qm_next = {qm[Stage-1:0], 1'b1};
    case (w_msd)
      2'b10: begin
        w_q_next  = {q[Stage-1:0], 1'b1};
        w_qm_next = {q[Stage-1:0], 1'b0};
      end
      2'b01: begin
        w_q_next  = {qm[Stage-1:0], 1'b1};
        w_qm_next = {qm[Stage-1:0], 1'b0};
      end
      default: begin
        w_q_next  = {q[Stage-1:0], 1'b0};
        w_qm_next = {qm[Stage-1:0], 1'b1};
      end
    endcase
  end

  // Narrowing of the final Q value to the output width.
  generate
    if (OUT_W == Stage + 1) begin : g_fit_full
      assign w_fit = w_q_next;
    end else begin : g_fit_narrow
`ifdef OTFC_SAT_EN
      localparam logic signed [Stage:0] C_MAX = {{(Stage + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
      localparam logic signed [Stage:0] C_MIN = {{(Stage + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};
      logic w_hi;
      logic w_lo;
      assign w_hi  = $signed(w_q_next) > C_MAX;
      assign w_lo  = $signed(w_q_next) < C_MIN;
      assign w_fit = w_hi ? {1'b0, {(OUT_W - 1){1'b1}}} :
                     w_lo ? {1'b1, {(OUT_W - 1){1'b0}}} :
                            w_q_next[OUT_W-1:0];
`else
      assign w_fit = w_q_next[OUT_W-1:0];
`endif
    end
  endgenerate

  // Handshake flags come straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Controller and datapath: load in IDLE, one digit per cycle in CONV,
  // result captured on the last digit, held in DONE until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      q     <= '0;
      qm    <= '1;
      cnt   <= '0;
      y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr    <= x;
            q     <= '0;
            qm    <= '1;
            cnt   <= '0;
            state <= CONV;
          end
        end
        CONV: begin
          sr  <= {sr[2*Stage-3:0], 2'b00};
          q   <= w_q_next;
          qm  <= w_qm_next;
          cnt <= cnt + CW'(1);
          if (cnt == C_LAST) begin
            y     <= w_fit;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_online_otf_convert.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_online_otf_convert                                           |
// | Brief    : Self-checking bench for online_otf_convert. A full-width and    |
// |            an 8-bit instance share stimulus; results are compared against  |
// |            the arithmetic value of the signed-digit word.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_online_otf_convert;

  localparam int STAGE = 9;
  localparam int W_FULL = STAGE + 1;
  localparam int W_NAR = 8;

  logic                 clk;
  logic                 rst;
  logic [2*STAGE-1:0]   x;
  logic                 in_valid;
  logic                 out_ready;
  logic                 in_ready;
  logic                 out_valid;
  logic [W_FULL-1:0]    y;
  logic                 in_ready8;
  logic                 out_valid8;
  logic [W_NAR-1:0]     y8;

  int n_tests;
  int n_fail;
  int cyc;

  online_otf_convert #(.Stage(STAGE), .OUT_W(W_FULL)) dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .out_valid(out_valid), .out_ready(out_ready)
  );

  online_otf_convert #(.Stage(STAGE), .OUT_W(W_NAR)) dut8 (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(in_ready8),
    .y(y8), .out_valid(out_valid8), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Integer value of a signed-digit word: sum of (pos - neg) * 2^j.
  function automatic int sd_value(input logic [2*STAGE-1:0] w);
    int v;
    v = 0;
    for (int j = 0; j < STAGE; j++)
      v += (int'(w[2*j+1]) - int'(w[2*j])) * (1 << j);
    return v;
  endfunction

  function automatic logic [31:0] exp_full(input int v);
    logic [31:0] t;
    t = v;
    return t & ((32'd1 << W_FULL) - 1);
  endfunction

  function automatic logic [31:0] exp_nar(input int v);
    int r;
    logic [31:0] t;
    r = v;
`ifdef OTFC_SAT_EN
    if (r > (1 << (W_NAR - 1)) - 1) r = (1 << (W_NAR - 1)) - 1;
    if (r < -(1 << (W_NAR - 1))) r = -(1 << (W_NAR - 1));
`endif
    t = r;
    return t & ((32'd1 << W_NAR) - 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, latency, result, optional backpressure, release.
  task automatic convert(input logic [2*STAGE-1:0] w, input int hold, input string tag);
    int lat;
    int v;
    int bad;
    logic [W_FULL-1:0] y_keep;
    v = sd_value(w);
    lat = 0;
    while (!in_ready && lat < 40) begin
      tick;
      lat++;
    end
    check({tag, " ready"}, {31'd0, in_ready}, 32'd1);
    x = w;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    x = $urandom;
    check({tag, " busy"}, {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick;
      lat++;
    end
    // accept edge plus Stage CONV edges, the last one loading y
    check({tag, " lat"}, lat, STAGE);
    check({tag, " y"}, {22'd0, y}, exp_full(v));
    check({tag, " y8"}, {24'd0, y8}, exp_nar(v));
    y_keep = y;
    bad = 0;
    for (int k = 0; k < hold; k++) begin
      in_valid = k[0];
      x = $urandom;
      tick;
      if (!out_valid || in_ready || y !== y_keep) bad++;
    end
    in_valid = 1'b0;
    if (hold > 0) check({tag, " hold"}, bad, 0);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, " idle"}, {30'd0, in_ready, out_valid}, 32'b10);
    check({tag, " ykeep"}, {22'd0, y}, {22'd0, y_keep});
  endtask

  logic [2*STAGE-1:0] words[3];
  int acc_t[3];
  int n_acc;
  int n_got;
  int bad;
  logic fire;
  logic acc;

  initial begin
    n_tests = 0;
    n_fail = 0;
    cyc = 0;
    rst = 1'b1;
    x = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick;
    tick;
    check("rst y", {22'd0, y}, 32'd0);
    check("rst flags", {30'd0, in_ready, out_valid}, 32'b10);
    rst = 1'b0;
    tick;

    // directed words
    convert(18'h00002, 0, "lsd+1");
    convert(18'h10000, 0, "msd-1");
    convert(18'h2AAAA, 0, "all+1");
    convert(18'h15555, 0, "all-1");
    convert(18'h24000, 0, "mixed");
    convert(18'h3FFFF, 0, "all11");
    convert(18'h2AAAA, 20, "bp");

    // no spurious second result after the backpressured word
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (out_valid) bad++;
    end
    check("no2nd", bad, 0);

    // reset in the middle of a conversion
    x = 18'h24000;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst flags", {30'd0, in_ready, out_valid}, 32'b10);
    check("midrst y", {22'd0, y}, 32'd0);
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      tick;
      if (out_valid) bad++;
    end
    check("midrst nov", bad, 0);

    // back-to-back throughput with out_ready held high
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    n_acc = 0;
    n_got = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    x = words[0];
    for (int k = 0; k < 80 && n_got < 3; k++) begin
      acc = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (fire) begin
        check("tp y", {22'd0, y}, exp_full(sd_value(words[n_got])));
        check("tp y8", {24'd0, y8}, exp_nar(sd_value(words[n_got])));
        n_got++;
      end
      if (acc) begin
        acc_t[n_acc] = cyc;
        n_acc++;
      end
      tick;
      if (acc) begin
        if (n_acc < 3) x = words[n_acc];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("tp count", n_got, 3);
    check("tp gap1", acc_t[1] - acc_t[0], STAGE + 2);
    check("tp gap2", acc_t[2] - acc_t[1], STAGE + 2);
    tick;

    // randomized words with random backpressure
    for (int i = 0; i < 25; i++)
      convert(18'($urandom), int'($urandom_range(0, 4)), "rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
